// File: rtl/iram_port_arb.sv
// rtl/iram_port_arb.sv - iram boot sequencer and CPU/loader port arbiter.
// Optional console snoop: define IRAM_PORT_ARB_CONSOLE_EN.
module iram_port_arb #(
  parameter int AW = 32,
  parameter int LINE_AW = 24,
  parameter int REL_CYCLES = 4,
  parameter int LD_MAX_WAIT = 8,
  parameter logic [AW-1:0] CONSOLE_ADDR = 32'h01ff_fff0
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               ld_req,
  output logic               ld_gnt,
  input  logic [AW-1:0]      ld_addr,
  input  logic [31:0]        ld_wdata,
  input  logic               ld_done,
  input  logic               cpu_req,
  output logic               cpu_gnt,
  input  logic               cpu_wen,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [127:0]       cpu_wdata,
  input  logic [15:0]        cpu_wstrb,
  output logic               cpu_rvalid,
  output logic [127:0]       cpu_rdata,
  output logic               ram_cen,
  output logic               ram_wen,
  output logic [LINE_AW-1:0] ram_addr,
  output logic [127:0]       ram_wdata,
  output logic [15:0]        ram_wstrb,
  input  logic [127:0]       ram_rdata,
  output logic               cpu_rst_hold,
  output logic               con_valid,
  output logic [7:0]         con_char
);

  localparam int WW = $clog2(LD_MAX_WAIT + 1);

  typedef enum logic [1:0] {ST_BOOT, ST_RELEASE, ST_RUN} state_t;

  state_t        state;
  logic [7:0]    rel_cnt;
  logic [WW-1:0] ld_wait;
  logic          rvalid_q;
  logic          forced;
  logic          ld_win;
  logic          cpu_win;

  // Before RUN the CPU is held in reset, so the loader owns the SRAM outright.
  always_comb begin
    forced  = (state == ST_RUN) && (ld_wait == WW'(LD_MAX_WAIT));
    ld_win  = 1'b0;
    cpu_win = 1'b0;
    if (rst_b) begin
      if (state != ST_RUN) begin
        ld_win = ld_req;
      end else begin
        cpu_win = cpu_req && !forced;
        ld_win  = ld_req && (!cpu_req || forced);
      end
    end
  end

  assign ld_gnt  = ld_win;
  assign cpu_gnt = cpu_win;

  always_comb begin
    ram_cen   = ld_win || cpu_win;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wstrb = '0;
    if (cpu_win) begin
      ram_wen   = cpu_wen;
      ram_addr  = cpu_addr[LINE_AW+3:4];
      ram_wdata = cpu_wdata;
      ram_wstrb = cpu_wen ? cpu_wstrb : 16'h0000;
    end else if (ld_win) begin
      ram_wen   = 1'b1;
      ram_addr  = ld_addr[LINE_AW+3:4];
      ram_wdata = {96'b0, ld_wdata} << {ld_addr[3:2], 5'b0};
      ram_wstrb = 16'h000f << {ld_addr[3:2], 2'b0};
    end
  end

  // rel_cnt holds REL_CYCLES on the first RELEASE cycle and the FSM enters RUN
  // as it steps 2->1, so the hold drops REL_CYCLES cycles after ld_done.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= ST_BOOT;
      cpu_rst_hold <= 1'b1;
      rel_cnt      <= 8'd0;
      ld_wait      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      rvalid_q <= cpu_win && !cpu_wen;

      if ((state == ST_RUN) && ld_req && !ld_win) begin
        if (ld_wait != WW'(LD_MAX_WAIT)) ld_wait <= ld_wait + 1'b1;
      end else begin
        ld_wait <= '0;
      end

      case (state)
        ST_BOOT: begin
          if (ld_done) begin
            rel_cnt <= 8'(REL_CYCLES);
            if (REL_CYCLES <= 1) begin
              state        <= ST_RUN;
              cpu_rst_hold <= 1'b0;
            end else begin
              state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          rel_cnt <= rel_cnt - 8'd1;
          if (rel_cnt <= 8'd2) begin
            state        <= ST_RUN;
            cpu_rst_hold <= 1'b0;
          end
        end
        ST_RUN: begin
          cpu_rst_hold <= 1'b0;
        end
        default: begin
          state        <= ST_BOOT;
          cpu_rst_hold <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rvalid_q ? ram_rdata : 128'b0;

`ifdef IRAM_PORT_ARB_CONSOLE_EN
  logic       con_hit;
  logic [7:0] con_sel;

  // Only a single fully-enabled 32-bit word counts as a console character.
  always_comb begin
    con_hit = 1'b0;
    con_sel = 8'h00;
    if (cpu_win && cpu_wen && (cpu_addr[AW-1:4] == CONSOLE_ADDR[AW-1:4])) begin
      case (cpu_wstrb)
        16'h000f: begin con_hit = 1'b1; con_sel = cpu_wdata[7:0];   end
        16'h00f0: begin con_hit = 1'b1; con_sel = cpu_wdata[39:32]; end
        16'h0f00: begin con_hit = 1'b1; con_sel = cpu_wdata[71:64]; end
        16'hf000: begin con_hit = 1'b1; con_sel = cpu_wdata[103:96]; end
        default:  begin con_hit = 1'b0; con_sel = 8'h00; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      con_valid <= 1'b0;
      con_char  <= 8'h00;
    end else begin
      con_valid <= con_hit;
      con_char  <= con_sel;
    end
  end
`else
  assign con_valid = 1'b0;
  assign con_char  = 8'h00;

  logic unused_console;
  assign unused_console = &{1'b0, CONSOLE_ADDR};
`endif

  logic unused_addr;
  assign unused_addr = &{1'b0, ld_addr[AW-1:LINE_AW+4], ld_addr[1:0],
                         cpu_addr[AW-1:LINE_AW+4], cpu_addr[3:0]};

endmodule

// File: tb/tb_iram_port_arb.sv
// tb/tb_iram_port_arb.sv - randomized self-checking bench for iram_port_arb.
`timescale 1ns/1ps
module tb_iram_port_arb;

  localparam int AW = 32;
  localparam int LINE_AW = 24;
  localparam int REL = 4;
  localparam int MAXW = 8;

  logic               clk = 1'b0;
  logic               rst_b = 1'b0;
  logic               ld_req = 1'b0, ld_done = 1'b0;
  logic               ld_gnt;
  logic [AW-1:0]      ld_addr = '0;
  logic [31:0]        ld_wdata = '0;
  logic               cpu_req = 1'b0, cpu_wen = 1'b0;
  logic               cpu_gnt;
  logic [AW-1:0]      cpu_addr = '0;
  logic [127:0]       cpu_wdata = '0;
  logic [15:0]        cpu_wstrb = '0;
  logic               cpu_rvalid;
  logic [127:0]       cpu_rdata;
  logic               ram_cen, ram_wen;
  logic [LINE_AW-1:0] ram_addr;
  logic [127:0]       ram_wdata;
  logic [15:0]        ram_wstrb;
  logic [127:0]       ram_rdata = '0;
  logic               cpu_rst_hold;
  logic               con_valid;
  logic [7:0]         con_char;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iram_port_arb #(.AW(AW), .LINE_AW(LINE_AW), .REL_CYCLES(REL), .LD_MAX_WAIT(MAXW),
                  .CONSOLE_ADDR(32'h01ff_fff0)) dut (
    .clk(clk), .rst_b(rst_b),
    .ld_req(ld_req), .ld_gnt(ld_gnt), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
    .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata), .cpu_rst_hold(cpu_rst_hold),
    .con_valid(con_valid), .con_char(con_char)
  );

  // Behavioural SRAM macro: byte-enable writes, registered read data.
  logic [127:0] sram [int];
  always @(posedge clk) begin : sram_model
    logic [127:0] line;
    if (ram_cen) begin
      line = sram.exists(int'(ram_addr)) ? sram[int'(ram_addr)] : 128'b0;
      if (ram_wen) begin
        for (int b = 0; b < 16; b++) if (ram_wstrb[b]) line[8*b +: 8] = ram_wdata[8*b +: 8];
        sram[int'(ram_addr)] = line;
      end else begin
        ram_rdata <= line;
      end
    end
  end

  // Reference model: timestamps, a refusal count and a byte-addressed memory.
  int           cyc = 0;
  int           done_at = -1;
  int           refused = 0;
  bit           rd_pend = 0;
  logic [127:0] rd_data = '0;
  logic [7:0]   ref_mem [int];

  bit                 e_ld, e_cpu, e_cen, e_wen, e_hold, e_rvalid;
  logic [LINE_AW-1:0] e_addr;
  logic [127:0]       e_wdata, e_rdata;
  logic [15:0]        e_wstrb;

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / 16) % (32'd1 << LINE_AW));
  endfunction

  function automatic logic [127:0] ref_line(input int ln);
    logic [127:0] r;
    for (int b = 0; b < 16; b++)
      r[8*b +: 8] = ref_mem.exists(ln*16 + b) ? ref_mem[ln*16 + b] : 8'h00;
    return r;
  endfunction

  function automatic bit in_run();
    return (done_at >= 0) && (cyc >= done_at + REL);
  endfunction

  task automatic model_reset();
    done_at = -1;
    refused = 0;
    rd_pend = 0;
  endtask

  task automatic model_eval();
    int k;
    e_hold = !in_run();
    if (!in_run()) begin
      e_cpu = 0;
      e_ld  = ld_req;
    end else begin
      e_cpu = cpu_req && (refused != MAXW);
      e_ld  = ld_req && (!cpu_req || refused == MAXW);
    end
    e_cen = e_ld || e_cpu;
    e_wen = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
    if (e_cpu) begin
      e_wen   = cpu_wen;
      e_addr  = LINE_AW'(line_of(cpu_addr));
      e_wdata = cpu_wdata;
      e_wstrb = cpu_wen ? cpu_wstrb : 16'h0;
    end else if (e_ld) begin
      k = int'((ld_addr % 16) / 4);
      e_wen  = 1;
      e_addr = LINE_AW'(line_of(ld_addr));
      for (int w = 0; w < 4; w++) begin
        e_wdata[32*w +: 32] = (w == k) ? ld_wdata : 32'h0;
        e_wstrb[4*w +: 4]   = (w == k) ? 4'hf : 4'h0;
      end
    end
    e_rvalid = rd_pend;
    e_rdata  = rd_pend ? rd_data : 128'b0;
  endtask

  task automatic model_commit();
    int ln, k;
    rd_pend = e_cpu && !cpu_wen;
    if (rd_pend) rd_data = ref_line(line_of(cpu_addr));
    if (e_cpu && cpu_wen) begin
      ln = line_of(cpu_addr);
      for (int b = 0; b < 16; b++) if (cpu_wstrb[b]) ref_mem[ln*16 + b] = cpu_wdata[8*b +: 8];
    end
    if (e_ld) begin
      ln = line_of(ld_addr);
      k  = int'((ld_addr % 16) / 4);
      for (int j = 0; j < 4; j++) ref_mem[ln*16 + k*4 + j] = ld_wdata[8*j +: 8];
    end
    if (in_run() && ld_req && !e_ld) refused = (refused < MAXW) ? refused + 1 : MAXW;
    else refused = 0;
    if (done_at < 0 && ld_done) done_at = cyc;
    cyc++;
  endtask

  task automatic set_idle();
    ld_req = 0; ld_done = 0; cpu_req = 0; cpu_wen = 0; cpu_wstrb = '0;
  endtask

  task automatic next_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    ld_req = 1; cpu_req = 1;
    @(negedge clk);
    checks++;
    if ({ld_gnt, cpu_gnt, ram_cen, cpu_rst_hold, cpu_rvalid, con_valid} !== 6'b000100 || con_char !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b/%b cen=%b hold=%b rvalid=%b con=%b/%h, expected 0/0 0 1 0 0/00",
               ld_gnt, cpu_gnt, ram_cen, cpu_rst_hold, cpu_rvalid, con_valid, con_char);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_b = 1;
    set_idle();
  endtask

  task automatic test_boot_load();
    int i = 0;
    while (i < 64) begin
      cpu_req = 1; cpu_wen = 1'($urandom); cpu_addr = $urandom; cpu_wstrb = 16'($urandom);
      ld_req  = ($urandom_range(0, 4) != 0);
      ld_addr = 32'(i*4) | 32'($urandom_range(0, 3));
      ld_wdata = $urandom;
      ld_done = ld_req && (i == 63);
      @(negedge clk);
      model_eval();
      checks++;
      if (cpu_gnt !== 1'b0 || cpu_rst_hold !== 1'b1 || ld_gnt !== ld_req) begin
        errors++;
        $display("FAIL boot_grants: got cpu_gnt=%b hold=%b ld_gnt=%b, expected 0 1 %b", cpu_gnt, cpu_rst_hold, ld_gnt, ld_req);
      end
      checks++;
      if (ram_cen !== e_cen || (e_cen && (ram_wen !== e_wen || ram_addr !== e_addr || ram_wstrb !== e_wstrb || ram_wdata !== e_wdata))) begin
        errors++;
        $display("FAIL boot_ram: got cen=%b wen=%b addr=%h strb=%h data=%h, expected %b %b %h %h %h",
                 ram_cen, ram_wen, ram_addr, ram_wstrb, ram_wdata, e_cen, e_wen, e_addr, e_wstrb, e_wdata);
      end
      if (ld_req && i == 2) begin
        checks++;
        if (ram_wstrb !== 16'h0f00 || ram_wdata !== {32'h0, ld_wdata, 64'h0}) begin
          errors++;
          $display("FAIL boot_lane2: got strb=%h data=%h, expected 0f00 with %h on [95:64]", ram_wstrb, ram_wdata, ld_wdata);
        end
      end
      if (ld_req) i++;
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_release();
    for (int k = 1; k <= REL; k++) begin
      cpu_req = 1; cpu_wen = 0; cpu_addr = 32'h30;
      ld_req  = (k < REL); ld_addr = 32'h100 + 32'(k*4); ld_wdata = $urandom;
      ld_done = (k == 2);
      @(negedge clk);
      model_eval();
      checks++;
      if (cpu_rst_hold !== (k < REL) || cpu_gnt !== (k >= REL) || ld_gnt !== (k < REL)) begin
        errors++;
        $display("FAIL release_k%0d: got hold=%b cpu_gnt=%b ld_gnt=%b, expected %b %b %b",
                 k, cpu_rst_hold, cpu_gnt, ld_gnt, k < REL, k >= REL, k < REL);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_read_latency();
    logic [127:0] l3, l4;
    l3 = ref_line(3);
    l4 = ref_line(4);
    cpu_req = 1; cpu_wen = 0; cpu_addr = 32'h30;
    @(negedge clk);
    model_eval();
    checks++;
    if (cpu_gnt !== 1'b1 || ram_addr !== 24'd3 || ram_wen !== 1'b0 || ram_cen !== 1'b1) begin
      errors++;
      $display("FAIL read_issue: got gnt=%b cen=%b wen=%b addr=%h, expected 1 1 0 000003", cpu_gnt, ram_cen, ram_wen, ram_addr);
    end
    next_cycle();
    cpu_addr = 32'h4c;
    @(negedge clk);
    model_eval();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== l3 || ram_addr !== 24'd4) begin
      errors++;
      $display("FAIL read_n1: got rvalid=%b rdata=%h addr=%h, expected 1 %h 000004", cpu_rvalid, cpu_rdata, ram_addr, l3);
    end
    next_cycle();
    cpu_req = 0;
    @(negedge clk);
    model_eval();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== l4) begin
      errors++;
      $display("FAIL read_n2: got rvalid=%b rdata=%h, expected 1 %h", cpu_rvalid, cpu_rdata, l4);
    end
    next_cycle();
    @(negedge clk);
    model_eval();
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 128'b0) begin
      errors++;
      $display("FAIL read_idle: got rvalid=%b rdata=%h, expected 0 0", cpu_rvalid, cpu_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    set_idle();
    @(negedge clk);
    model_eval();
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      cpu_req = 1; cpu_wen = 1; cpu_addr = 32'($urandom_range(0, 15) * 16); cpu_wstrb = 16'($urandom);
      cpu_wdata = {$urandom, $urandom, $urandom, $urandom};
      ld_req = 1; ld_addr = 32'($urandom_range(0, 63) * 4); ld_wdata = $urandom;
      @(negedge clk);
      model_eval();
      checks++;
      if (cpu_gnt !== (i != 8) || ld_gnt !== (i == 8)) begin
        errors++;
        $display("FAIL starve_cycle%0d: got cpu_gnt=%b ld_gnt=%b, expected %b %b", i + 1, cpu_gnt, ld_gnt, i != 8, i == 8);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      ld_req   = 1'($urandom);
      ld_addr  = ($urandom & 32'hf000_0000) | 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
      ld_wdata = $urandom;
      ld_done  = ($urandom_range(0, 19) == 0);
      cpu_req  = ($urandom_range(0, 2) != 0);
      cpu_wen  = 1'($urandom);
      cpu_addr = ($urandom & 32'hf000_0000) | 32'($urandom_range(0, 255));
      cpu_wstrb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      cpu_wdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      model_eval();
      checks++;
      if ({ld_gnt, cpu_gnt, ram_cen, cpu_rst_hold, cpu_rvalid, con_valid} !== {e_ld, e_cpu, e_cen, e_hold, e_rvalid, 1'b0}) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: got ld/cpu/cen/hold/rv/con=%b%b%b%b%b%b, expected %b%b%b%b%b0",
                 cyc, ld_gnt, cpu_gnt, ram_cen, cpu_rst_hold, cpu_rvalid, con_valid, e_ld, e_cpu, e_cen, e_hold, e_rvalid);
      end
      checks++;
      if (cpu_rdata !== e_rdata || (e_cen && (ram_wen !== e_wen || ram_addr !== e_addr || ram_wstrb !== e_wstrb ||
          (e_wen && ram_wdata !== e_wdata)))) begin
        errors++;
        $display("FAIL rand_data@%0d: got rdata=%h wen=%b addr=%h strb=%h, expected %h %b %h %h",
                 cyc, cpu_rdata, ram_wen, ram_addr, ram_wstrb, e_rdata, e_wen, e_addr, e_wstrb);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1; cpu_wen = 0; cpu_addr = 32'h20;
    @(negedge clk);
    model_eval();
    next_cycle();
    rst_b = 0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rst_hold !== 1'b1 || cpu_gnt !== 1'b0 || ram_cen !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got rvalid=%b hold=%b gnt=%b cen=%b, expected 0 1 0 0", cpu_rvalid, cpu_rst_hold, cpu_gnt, ram_cen);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_b = 1;
    ld_req = 1; ld_addr = 32'h44; ld_wdata = $urandom; ld_done = 1;
    @(negedge clk);
    model_eval();
    checks++;
    if (ld_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_rst_hold !== 1'b1 || cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_boot: got ld_gnt=%b cpu_gnt=%b hold=%b rvalid=%b, expected 1 0 1 0", ld_gnt, cpu_gnt, cpu_rst_hold, cpu_rvalid);
    end
    next_cycle();
    set_idle();
    cpu_req = 1; cpu_wen = 0;
    for (int k = 1; k <= REL; k++) begin
      @(negedge clk);
      model_eval();
      checks++;
      if (cpu_rst_hold !== e_hold || cpu_gnt !== e_cpu) begin
        errors++;
        $display("FAIL rerelease_k%0d: got hold=%b gnt=%b, expected %b %b", k, cpu_rst_hold, cpu_gnt, e_hold, e_cpu);
      end
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_console();
    logic [15:0] strbs [2];
    strbs[0] = 16'h00f0;
    strbs[1] = 16'h00ff;
    for (int t = 0; t < 2; t++) begin
      cpu_req = 1; cpu_wen = 1; cpu_addr = 32'h01ff_fff0; cpu_wstrb = strbs[t];
      cpu_wdata = {$urandom, $urandom, $urandom, $urandom};
      cpu_wdata[39:32] = 8'h41;
      @(negedge clk);
      model_eval();
      next_cycle();
      set_idle();
      @(negedge clk);
      model_eval();
      checks++;
`ifdef IRAM_PORT_ARB_CONSOLE_EN
      if (con_valid !== (t == 0) || (t == 0 && con_char !== 8'h41)) begin
        errors++;
        $display("FAIL console_t%0d: got valid=%b char=%h, expected %b 41", t, con_valid, con_char, t == 0);
      end
`else
      if (con_valid !== 1'b0 || con_char !== 8'h00) begin
        errors++;
        $display("FAIL console_off_t%0d: got valid=%b char=%h, expected 0 00", t, con_valid, con_char);
      end
`endif
      next_cycle();
      @(negedge clk);
      model_eval();
      checks++;
      if (con_valid !== 1'b0) begin
        errors++;
        $display("FAIL console_pulse_t%0d: got valid=%b, expected 0", t, con_valid);
      end
      next_cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boot_load();
    test_release();
    test_read_latency();
    test_starvation();
    test_random(400);
    test_reset_mid_read();
    test_console();
    test_random(200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iram_port_arb.md
Name: iram_port_arb

Overview:
- Sequences and shares the 128-bit, 16-byte-lane instruction/data SRAM (iram) between the CPU subsystem memory port and a 32-bit program-loader write port.
- Holds the CPU in reset while the loader fills the memory, then releases the CPU and arbitrates both requesters at runtime.
- Sits between the SoC memory slave logic and the iram macro.

Parameters:
- AW, 32, byte address width of both requester ports.
- LINE_AW, 24, SRAM line index width; ram_addr = addr[LINE_AW+3:4].
- REL_CYCLES, 4, cycles between loader completion and cpu_rst_hold deassertion (range 1..255).
- LD_MAX_WAIT, 8, RUN-state cycles a pending loader request may be refused before it is forced to win.
- CONSOLE_ADDR, 32'h01ff_fff0, console snoop address (optional feature only).

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- ld_req  in  1  loader write request
- ld_gnt  out  1  loader grant; transfer occurs when ld_req && ld_gnt
- ld_addr  in  AW  loader byte address (word aligned, [1:0] ignored)
- ld_wdata  in  32  loader write word
- ld_done  in  1  single-cycle pulse: program load complete
- cpu_req  in  1  CPU request
- cpu_gnt  out  1  CPU grant; transfer occurs when cpu_req && cpu_gnt
- cpu_wen  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU byte address ([3:0] ignored)
- cpu_wdata  in  128  CPU write data
- cpu_wstrb  in  16  CPU byte strobes
- cpu_rvalid  out  1  read data valid
- cpu_rdata  out  128  read data
- ram_cen  out  1  SRAM access enable (active high)
- ram_wen  out  1  SRAM write
- ram_addr  out  LINE_AW  SRAM line index
- ram_wdata  out  128  SRAM write data
- ram_wstrb  out  16  SRAM byte enables
- ram_rdata  in  128  SRAM read data, valid one cycle after a read access
- cpu_rst_hold  out  1  1 = hold CPU in reset
- con_valid  out  1  console character strobe (optional feature)
- con_char  out  8  console character (optional feature)

Behaviour:
- Reset: state=BOOT, cpu_rst_hold=1, cpu_rvalid=0, ld_wait=0, rel_cnt=0, con_valid=0, con_char=0.
- Reset effect on combinational outputs: ld_gnt, cpu_gnt and ram_cen evaluate to 0 while rst_b=0.
- Asynchronous reset mid-operation: any pending rvalid is dropped, state returns to BOOT and cpu_rst_hold reasserts immediately.
- Grants are combinational, same cycle as the request. At most one grant per cycle.
- ram_* outputs are driven combinationally from the winner. ram_cen=0 when there is no winner.
- Loader write mapping: k=ld_addr[3:2]; ram_wdata[32k+31:32k]=ld_wdata; ram_wstrb=4'hf<<4k; other data lanes 0; ram_wen=1.
- CPU access: ram_wen=cpu_wen; ram_wstrb=cpu_wen?cpu_wstrb:16'h0.
- A CPU write with cpu_wstrb=0 is still granted; the SRAM is not modified.
- Read latency: cpu_rvalid=1 exactly one cycle after a granted CPU read; cpu_rdata=ram_rdata when cpu_rvalid, else 0.
- Back-to-back CPU reads give rvalid on consecutive cycles.
- BOOT state:
  - ld_gnt=ld_req; cpu_gnt=0; cpu_rst_hold=1.
  - On ld_done: go to RELEASE and load rel_cnt=REL_CYCLES.
  - If ld_done coincides with ld_req, that write still completes.
- RELEASE state:
  - ld_gnt=ld_req; cpu_gnt=0.
  - rel_cnt decrements each cycle; at 1, go to RUN.
  - cpu_rst_hold deasserts on the first RUN cycle, exactly REL_CYCLES cycles after the ld_done cycle.
  - ld_done during RELEASE is ignored.
- RUN state:
  - CPU has priority: cpu_gnt=cpu_req unless forced.
  - ld_gnt=ld_req && (!cpu_req || forced).
  - forced = (ld_wait == LD_MAX_WAIT).
  - ld_wait increments (saturating) on ld_req && !ld_gnt; clears on a loader grant or when !ld_req.
  - ld_done in RUN is ignored.
- Line addresses wrap modulo 2^LINE_AW; upper address bits are ignored.

Optional Feature:
- Macro: IRAM_PORT_ARB_CONSOLE_EN.
- When defined, a granted CPU write with cpu_addr[AW-1:4]==CONSOLE_ADDR[AW-1:4] produces con_valid=1 on the next cycle.
- con_char is taken from the lowest byte of the single enabled word:
  - cpu_wstrb=16'h000f: wdata[7:0]
  - cpu_wstrb=16'h00f0: wdata[39:32]
  - cpu_wstrb=16'h0f00: wdata[71:64]
  - cpu_wstrb=16'hf000: wdata[103:96]
  - any other strobe pattern: no strobe.
- The write is still forwarded to the SRAM.
- When not defined, con_valid and con_char are tied to 0 and no snoop logic exists.

Test Plan:
- Boot load: 64 loader writes, ld_addr=0x0..0xFC, with cpu_req=1 held -> cpu_gnt stays 0. Write at ld_addr=0x8 has ram_wstrb=16'h0f00 and data on [95:64].
- Release timing: ld_done pulse at cycle T, REL_CYCLES=4 -> cpu_rst_hold falls at T+4; first cpu_gnt no earlier than T+4.
- Read latency: CPU read of line 3 in RUN -> ram_addr=3 and ram_wen=0 in cycle N; cpu_rvalid=1 in N+1 with cpu_rdata=ram_rdata. Reads at N, N+1 give rvalid at N+1, N+2.
- Starvation: in RUN, cpu_req held 1 and ld_req held 1 -> CPU granted 8 cycles, loader granted on the 9th cycle, CPU regrant on the next cycle.
- Reset mid-read: rst_b low in the cycle after a granted read -> cpu_rvalid=0, cpu_rst_hold=1, state=BOOT.
- Console (macro defined): CPU write to 0x01ff_fff0, wstrb=16'h00f0, wdata[39:32]=8'h41 -> con_valid=1 with con_char=8'h41 for one cycle. With wstrb=16'h00ff -> no strobe.
